// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// mult/multu/div/divu latch their operands on start, run for a fixed number
// of cycles, then commit to HI/LO. mthi/mtlo write directly when idle.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        MDSel,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        a_reg, a_next;
    logic [31:0]        b_reg, b_next;
    logic [2:0]         op_reg, op_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;

    logic               is_md_op;
    logic               is_div_op;
    logic [63:0]        prod;
    logic               div_signed;
    logic [31:0]        dvd_mag, dvs_mag, dvs_safe;
    logic [31:0]        uq, ur;
    logic [31:0]        res_hi, res_lo;
    logic               res_write;

    // Decode whether the E-stage op is a multi-cycle arithmetic op.
    always_comb begin
        is_md_op  = (MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
                    (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
        is_div_op = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
    end

    assign busy  = (state_reg == RUN);
    assign start = is_md_op && (state_reg == IDLE);
    assign HI    = hi_reg;
    assign LO    = lo_reg;
    assign MDOut = MDSel ? hi_reg : lo_reg;

    // Result datapath from the latched operands. Signed division is done on
    // magnitudes and the signs are restored afterwards, which also yields
    // 0x80000000 / -1 = 0x80000000 rem 0 without special casing.
    always_comb begin
        if (op_reg == OP_MULT) begin
            prod = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
        end else begin
            prod = {32'd0, a_reg} * {32'd0, b_reg};
        end

        div_signed = (op_reg == OP_DIV);
        dvd_mag    = (div_signed && a_reg[31]) ? (~a_reg + 32'd1) : a_reg;
        dvs_mag    = (div_signed && b_reg[31]) ? (~b_reg + 32'd1) : b_reg;
        // A zero divisor never commits; substitute 1 to keep the divider defined.
        dvs_safe   = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
        uq         = dvd_mag / dvs_safe;
        ur         = dvd_mag % dvs_safe;

        res_hi    = prod[63:32];
        res_lo    = prod[31:0];
        res_write = 1'b1;
        if ((op_reg == OP_DIV) || (op_reg == OP_DIVU)) begin
            res_lo    = (div_signed && (a_reg[31] ^ b_reg[31])) ? (~uq + 32'd1) : uq;
            res_hi    = (div_signed && a_reg[31]) ? (~ur + 32'd1) : ur;
            res_write = (b_reg != 32'd0);
        end
    end

    // Next-state and register-update logic for the IDLE/RUN controller.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    a_next     = A;
                    b_next     = B;
                    op_next    = MDOp;
                    cnt_next   = is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else if (MDOp == OP_MTHI) begin
                    hi_next = A;
                end else if (MDOp == OP_MTLO) begin
                    lo_next = A;
                end
            end
            RUN: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (res_write) begin
                        hi_next = res_hi;
                        lo_next = res_lo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed scenarios plus randomized ops checked
// against an arithmetic reference model of HI/LO.
module tb_mul_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic [2:0]  MDOp  = '0;
    logic        MDSel = 1'b0;
    wire         start;
    wire         busy;
    wire  [31:0] MDOut;
    wire  [31:0] HI;
    wire  [31:0] LO;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDOp  (MDOp),
        .MDSel (MDSel),
        .start (start),
        .busy  (busy),
        .MDOut (MDOut),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: what HI/LO become once the op completes.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, q, r;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            3'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
            3'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int exp_busy(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MC;
        if (op == 3'd3 || op == 3'd4) return DC;
        return 0;
    endfunction

    // Issue one op from mid-cycle; returns observed busy length, start in
    // cycle 0, and whether HI/LO stayed put with start low during RUN.
    // Ends at the falling edge of the first non-busy cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output int nb, output logic s0, output bit mid_ok);
        logic [31:0] hi0, lo0;
        hi0 = HI;
        lo0 = LO;
        MDOp = op; A = a; B = b;
        #1;
        s0 = start;
        @(posedge clk); #1;
        MDOp = scramble ? (($urandom_range(0, 1) == 0) ? 3'd1 : 3'd6) : 3'd0;
        if (scramble) begin A = $urandom; B = $urandom; end
        nb = 0;
        mid_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (start !== 1'b0 || HI !== hi0 || LO !== lo0) mid_ok = 1'b0;
            @(posedge clk); #1;
            MDOp = scramble ? (($urandom_range(0, 1) == 0) ? 3'd1 : 3'd6) : 3'd0;
            if (scramble) begin A = $urandom; B = $urandom; end
        end
        MDOp = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({HI, LO, MDOut, busy, start} !== '0)
            $display("FAIL reset_outputs: HI=%h LO=%h MDOut=%h busy=%b start=%b required all zero", HI, LO, MDOut, busy, start);
        else passes++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b required 0", busy);
        else passes++;
    endtask

    task automatic test_mult();
        int nb; logic s0; bit mo;
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, nb, s0, mo);
        model_op(3'd1, 32'hFFFFFFFF, 32'd2);
        checks++;
        if (nb !== MC) $display("FAIL mult_busy_len: got %0d required %0d", nb, MC); else passes++;
        checks++;
        if (s0 !== 1'b1 || !mo) $display("FAIL mult_start_hold: start0=%b mid_ok=%0d required 1/1", s0, mo); else passes++;
        checks++;
        if ({HI, LO} !== {m_hi, m_lo}) $display("FAIL mult_result: got %h_%h required %h_%h", HI, LO, m_hi, m_lo); else passes++;
    endtask

    task automatic test_multu();
        int nb; logic s0; bit mo;
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, nb, s0, mo);
        model_op(3'd2, 32'hFFFFFFFF, 32'd2);
        checks++;
        if (nb !== MC || s0 !== 1'b1) $display("FAIL multu_timing: busy=%0d start0=%b required %0d/1", nb, s0, MC); else passes++;
        checks++;
        if ({HI, LO} !== {m_hi, m_lo}) $display("FAIL multu_result: got %h_%h required %h_%h", HI, LO, m_hi, m_lo); else passes++;
    endtask

    task automatic test_div();
        int nb; logic s0; bit mo;
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, nb, s0, mo);
        model_op(3'd3, 32'hFFFFFFF9, 32'd2);
        checks++;
        if (nb !== DC) $display("FAIL div_busy_len: got %0d required %0d", nb, DC); else passes++;
        checks++;
        if ({HI, LO} !== {m_hi, m_lo}) $display("FAIL div_result: got %h_%h required %h_%h", HI, LO, m_hi, m_lo); else passes++;
        run_op(3'd4, 32'd7, 32'd2, 1'b0, nb, s0, mo);
        model_op(3'd4, 32'd7, 32'd2);
        checks++;
        if ({HI, LO} !== {m_hi, m_lo}) $display("FAIL divu_result: got %h_%h required %h_%h", HI, LO, m_hi, m_lo); else passes++;
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, nb, s0, mo);
        model_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        checks++;
        if ({HI, LO} !== {m_hi, m_lo}) $display("FAIL div_overflow: got %h_%h required %h_%h", HI, LO, m_hi, m_lo); else passes++;
    endtask

    task automatic test_mthi_divzero();
        int nb; logic s0; bit mo;
        run_op(3'd5, 32'h12345678, 32'd0, 1'b0, nb, s0, mo);
        model_op(3'd5, 32'h12345678, 32'd0);
        checks++;
        if (HI !== m_hi || nb !== 0 || s0 !== 1'b0)
            $display("FAIL mthi_write: HI=%h busy=%0d start=%b required %h/0/0", HI, nb, s0, m_hi);
        else passes++;
        run_op(3'd3, 32'd99, 32'd0, 1'b0, nb, s0, mo);
        model_op(3'd3, 32'd99, 32'd0);
        checks++;
        if (nb !== DC || {HI, LO} !== {m_hi, m_lo})
            $display("FAIL div_by_zero: busy=%0d HI/LO=%h_%h required %0d %h_%h", nb, HI, LO, DC, m_hi, m_lo);
        else passes++;
    endtask

    task automatic test_run_isolation();
        int nb; logic s0; bit mo;
        run_op(3'd3, 32'd1000, 32'd7, 1'b1, nb, s0, mo);
        model_op(3'd3, 32'd1000, 32'd7);
        checks++;
        if (!mo || nb !== DC) $display("FAIL run_isolation: mid_ok=%0d busy=%0d required 1/%0d", mo, nb, DC); else passes++;
        checks++;
        if ({HI, LO} !== {m_hi, m_lo}) $display("FAIL latched_operands: got %h_%h required %h_%h", HI, LO, m_hi, m_lo); else passes++;
    endtask

    task automatic test_reset_mid_run();
        int nb; logic s0; bit mo;
        int seen;
        run_op(3'd1, 32'h00010001, 32'h00030007, 1'b0, nb, s0, mo);
        model_op(3'd1, 32'h00010001, 32'h00030007);
        MDOp = 3'd3; A = 32'd500; B = 32'd3;
        @(posedge clk); #1;
        MDOp = 3'd0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy === 1'b1) seen++;
        end
        reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        checks++;
        if (seen !== 4 || busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            $display("FAIL reset_mid_run: seen_busy=%0d busy=%b HI=%h LO=%h required 4/0/0/0", seen, busy, HI, LO);
        else passes++;
        #2;
        reset = 1'b0;
        repeat (DC + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || {HI, LO} !== {m_hi, m_lo})
            $display("FAIL reset_discard: busy=%b HI/LO=%h_%h required 0 %h_%h", busy, HI, LO, m_hi, m_lo);
        else passes++;
    endtask

    task automatic test_mfhi_mflo();
        int nb; logic s0; bit mo;
        run_op(3'd1, 32'd3, 32'd4, 1'b0, nb, s0, mo);
        model_op(3'd1, 32'd3, 32'd4);
        MDSel = 1'b0; #1;
        checks++;
        if (MDOut !== m_lo) $display("FAIL mflo_read: got %h required %h", MDOut, m_lo); else passes++;
        MDSel = 1'b1; #1;
        checks++;
        if (MDOut !== m_hi) $display("FAIL mfhi_read: got %h required %h", MDOut, m_hi); else passes++;
    endtask

    task automatic test_random();
        int nb; logic s0; bit mo;
        logic [2:0] op; logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(1, 6));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9)) * (($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFFFFFF);
            run_op(op, a, b, ($urandom_range(0, 1) == 1), nb, s0, mo);
            model_op(op, a, b);
            MDSel = $urandom_range(0, 1);
            #1;
            checks++;
            if (nb !== exp_busy(op) || s0 !== (op <= 3'd4) || !mo)
                $display("FAIL rand_timing[%0d]: op=%0d busy=%0d start0=%b mid_ok=%0d required %0d/%b/1", n, op, nb, s0, mo, exp_busy(op), (op <= 3'd4));
            else passes++;
            checks++;
            if ({HI, LO} !== {m_hi, m_lo} || MDOut !== (MDSel ? m_hi : m_lo))
                $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h_%h out=%h required %h_%h", n, op, a, b, HI, LO, MDOut, m_hi, m_lo);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mthi_divzero();
        test_run_isolation();
        test_reset_mid_run();
        test_mfhi_mflo();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. Implements mult, multu, div, divu as fixed-latency multi-cycle operations, plus mthi/mtlo writes and mfhi/mflo reads of the HI/LO registers. Drives the `start` and `busy` signals consumed by the hazard/stall unit. The stall unit holds any D-stage multiply/divide-class instruction while `start | busy` is high.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- A  input  32  E-stage forwarded rs value
- B  input  32  E-stage forwarded rt value
- MDOp  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- MDSel  input  1  read select for `MDOut`: 0 = LO (mflo), 1 = HI (mfhi)
- start  output  1  combinational; high when MDOp ∈ {1..4} and not busy
- busy  output  1  registered; high while an operation is in flight
- MDOut  output  32  combinational read of HI or LO per MDSel
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- State machine: IDLE, RUN.
  - IDLE → RUN on a clock edge with `start`=1.
  - RUN → IDLE on the edge where the counter reaches zero.
- On entry to RUN (`start` edge):
  - latch A, B and op into operand registers; later changes on A/B/MDOp are ignored.
  - load the counter with MULT_CYCLES or DIV_CYCLES; set busy=1.
- In RUN: the counter decrements each edge.
  - At the edge where the counter goes 1→0, write the result to HI/LO and clear busy.
- Arithmetic:
  - mult: signed 32×32 → 64-bit product; HI=[63:32], LO=[31:0].
  - multu: the same, with unsigned operands.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (B=0 at latch): runs full DIV_CYCLES; HI and LO are left unchanged.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo:
  - In IDLE: write A into HI/LO at the clock edge; no busy.
  - In RUN: ignored. The stall unit guarantees this does not occur.
- `start` is suppressed while busy. MDOp ∈ {1..4} during RUN has no effect.
- MDOut, HI and LO always show the committed registers. Results are never forwarded mid-operation.
- Reset, asynchronous and at any time including mid-RUN:
  - HI=0, LO=0, busy=0, counter=0, state IDLE.
  - The in-flight operation is discarded.

## Timing
- Cycle 0: MDOp=mult in E. `start`=1 combinationally in the same cycle.
- Cycles 1..MULT_CYCLES: busy=1.
- Cycle MULT_CYCLES+1: busy=0 and new HI/LO are visible.
- Div: identical timing with DIV_CYCLES.
- The earliest next start is the first cycle with busy=0. Back-to-back ops have no dead cycle beyond that.
- mthi/mtlo: HI/LO updated at the edge ending cycle 0; visible in cycle 1.
- MDOut follows MDSel and the HI/LO registers combinationally, with zero latency.
- All outputs are 0 after reset.

## Test plan
- Reset, then mult A=0xFFFFFFFF, B=2:
  - busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. `start`=1 only in cycle 0.
- div A=0xFFFFFFF9 (−7), B=2:
  - busy=1 for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2 → LO=3, HI=1.
- mthi A=0x12345678 in IDLE → HI=0x12345678 next cycle with busy=0. Then div B=0 → HI/LO unchanged after 10 busy cycles.
- During RUN of a div:
  - drive MDOp=mult and mtlo with changing A/B → `start`=0, LO untouched, final result from latched operands.
  - Assert reset at busy cycle 4 → busy=0, HI=LO=0 immediately, before the next clock edge.
- mfhi/mflo: after mult 3×4, MDSel=0 → MDOut=12 and MDSel=1 → MDOut=0, switching in the same cycle.
